// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit byte writer: state encoding,
// LCD command constants and the slow-command classifier.
package lcd_pkg;

    typedef logic [3:0] lcd_state_t;

    localparam lcd_state_t PWR_WAIT   = 4'd0;
    localparam lcd_state_t INIT_SETUP = 4'd1;
    localparam lcd_state_t INIT_EHI   = 4'd2;
    localparam lcd_state_t INIT_WAIT  = 4'd3;
    localparam lcd_state_t IDLE       = 4'd4;
    localparam lcd_state_t HI_SETUP   = 4'd5;
    localparam lcd_state_t HI_EHI     = 4'd6;
    localparam lcd_state_t GAP        = 4'd7;
    localparam lcd_state_t LO_SETUP   = 4'd8;
    localparam lcd_state_t LO_EHI     = 4'd9;
    localparam lcd_state_t CMD_WAIT   = 4'd10;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT  = 8'h03;
    localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    // Clear and return-home need the long execution delay on the panel.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte-wide valid/ready channel from a producer into the LCD byte writer.
interface lcd_byte_writer_if;
    logic       in_valid;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_rs, output in_data, input in_ready);
    modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed state; done while the count sits at zero.
module lcd_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit feeder: power-on init nibbles, then byte writes split into
// high/low nibbles with programmable setup, E-high, gap and post-command delays.
//
// state      | meaning
// PWR_WAIT   | power-up settle before the first init nibble
// INIT_SETUP | init nibble on D, E low
// INIT_EHI   | init nibble strobe, E high
// INIT_WAIT  | long wait after each init nibble
// IDLE       | in_ready high, waiting for a byte
// HI_SETUP   | high nibble and RS on the pins, E low
// HI_EHI     | high nibble strobe
// GAP        | E low, high nibble held
// LO_SETUP   | low nibble on D, E low
// LO_EHI     | low nibble strobe
// CMD_WAIT   | post-byte execution delay (long for clear/home)
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 1,
    parameter int E_HIGH_CYC   = 4,
    parameter int NIB_GAP_CYC  = 4,
    parameter int CMD_DLY_CYC  = 64,
    parameter int LONG_DLY_CYC = 2048,
    parameter int PWR_DLY_CYC  = 16384,
    parameter int INIT_EN      = 1
) (
    input  logic               clk,
    input  logic               rst,
    lcd_byte_writer_if.slave   bus,
    output logic               init_done,
    output logic               lcd_rs,
    output logic [3:0]         lcd_d,
    output logic               lcd_e
);

    localparam int MAX_DLY = max_int(PWR_DLY_CYC, max_int(LONG_DLY_CYC, max_int(CMD_DLY_CYC,
                             max_int(NIB_GAP_CYC, max_int(E_HIGH_CYC, SETUP_CYC)))));
    localparam int CNT_W   = $clog2(MAX_DLY) + 1;
    localparam lcd_state_t RST_STATE = (INIT_EN != 0) ? PWR_WAIT : IDLE;

    lcd_state_t       state;
    lcd_state_t       state_nxt;
    logic [2:0]       init_cnt;
    logic             byte_rs;
    logic [7:0]       byte_data;
    logic             in_ready_q;
    logic             accept;
    logic             cnt_done;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    int               dly;

    assign accept       = (state == IDLE) && in_ready_q && bus.in_valid;
    assign bus.in_ready = in_ready_q;

    always_comb begin
        state_nxt = state;
        if (rst) begin
            state_nxt = RST_STATE;
        end else begin
            case (state)
                PWR_WAIT:   if (cnt_done) state_nxt = INIT_SETUP;
                INIT_SETUP: if (cnt_done) state_nxt = INIT_EHI;
                INIT_EHI:   if (cnt_done) state_nxt = INIT_WAIT;
                INIT_WAIT:  if (cnt_done) state_nxt = (init_cnt == 3'd4) ? IDLE : INIT_SETUP;
                IDLE:       if (accept)   state_nxt = HI_SETUP;
                HI_SETUP:   if (cnt_done) state_nxt = HI_EHI;
                HI_EHI:     if (cnt_done) state_nxt = GAP;
                GAP:        if (cnt_done) state_nxt = LO_SETUP;
                LO_SETUP:   if (cnt_done) state_nxt = LO_EHI;
                LO_EHI:     if (cnt_done) state_nxt = CMD_WAIT;
                CMD_WAIT:   if (cnt_done) state_nxt = IDLE;
                default:    state_nxt = RST_STATE;
            endcase
        end
    end

    // The counter is reloaded on every state entry with the length of the state being entered.
    always_comb begin
        dly = 1;
        case (state_nxt)
            PWR_WAIT:                       dly = PWR_DLY_CYC;
            INIT_SETUP, HI_SETUP, LO_SETUP: dly = SETUP_CYC;
            INIT_EHI, HI_EHI, LO_EHI:       dly = E_HIGH_CYC;
            GAP:                            dly = NIB_GAP_CYC;
            INIT_WAIT:                      dly = LONG_DLY_CYC;
            CMD_WAIT:                       dly = is_long_cmd(byte_rs, byte_data) ? LONG_DLY_CYC
                                                                                  : CMD_DLY_CYC;
            default:                        dly = 1;
        endcase
        cnt_val  = CNT_W'(dly - 1);
        cnt_load = rst || (state_nxt != state);
    end

    lcd_delay_cnt #(.W(CNT_W)) u_delay_cnt (
        .clk      (clk),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            init_cnt   <= 3'd0;
            byte_rs    <= 1'b0;
            byte_data  <= 8'h00;
            in_ready_q <= 1'b0;
            init_done  <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_d      <= 4'h0;
        end else begin
            state      <= state_nxt;
            lcd_e      <= (state_nxt == INIT_EHI) || (state_nxt == HI_EHI) || (state_nxt == LO_EHI);
            in_ready_q <= (state_nxt == IDLE);
            if (state_nxt == IDLE) init_done <= 1'b1;
            if (state == INIT_EHI && cnt_done) init_cnt <= init_cnt + 3'd1;
            if (accept) begin
                byte_rs   <= bus.in_rs;
                byte_data <= bus.in_data;
            end
            // Pins only move on entry to a setup state, so they are stable around every E pulse.
            if (state_nxt != state) begin
                case (state_nxt)
                    INIT_SETUP: begin
                        lcd_rs <= 1'b0;
                        lcd_d  <= (init_cnt == 3'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
                    end
                    HI_SETUP: begin
                        lcd_rs <= bus.in_rs;
                        lcd_d  <= bus.in_data[7:4];
                    end
                    LO_SETUP: lcd_d <= byte_data[3:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: cycle-by-cycle pin checks against a
// segment-timing model of the init sequence and of each byte write.
module tb_lcd_byte_writer;

    localparam int S  = 1;
    localparam int EH = 2;
    localparam int G  = 2;
    localparam int CD = 5;
    localparam int LD = 20;
    localparam int PD = 30;
    localparam int INIT_LEN = PD + 4 * (S + EH + LD);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst0;
    logic       done1, rs1, e1, done0, rs0, e0;
    logic [3:0] d1, d0;

    lcd_byte_writer_if bus1();
    lcd_byte_writer_if bus0();

    lcd_byte_writer #(
        .SETUP_CYC(S), .E_HIGH_CYC(EH), .NIB_GAP_CYC(G), .CMD_DLY_CYC(CD),
        .LONG_DLY_CYC(LD), .PWR_DLY_CYC(PD), .INIT_EN(1)
    ) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1),
        .init_done(done1), .lcd_rs(rs1), .lcd_d(d1), .lcd_e(e1)
    );

    lcd_byte_writer #(
        .SETUP_CYC(S), .E_HIGH_CYC(EH), .NIB_GAP_CYC(G), .CMD_DLY_CYC(CD),
        .LONG_DLY_CYC(LD), .PWR_DLY_CYC(PD), .INIT_EN(0)
    ) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0),
        .init_done(done0), .lcd_rs(rs0), .lcd_d(d0), .lcd_e(e0)
    );

    int total = 0;
    int bad   = 0;

    // Packed view {init_done, in_ready, lcd_e, lcd_rs, lcd_d}
    wire [7:0] obs1 = {done1, bus1.in_ready, e1, rs1, d1};
    wire [7:0] obs0 = {done0, bus0.in_ready, e0, rs0, d0};

    function automatic logic [7:0] exp_init(input int t);
        int per, u, n, r;
        per = S + EH + LD;
        if (t < PD) return 8'h00;
        u = t - PD;
        if (u < 4 * per) begin
            n = u / per;
            r = u % per;
            return {1'b0, 1'b0, (r >= S && r < S + EH), 1'b0, (n == 3) ? 4'h2 : 4'h3};
        end
        return {1'b1, 1'b1, 1'b0, 1'b0, 4'h2};
    endfunction

    function automatic int byte_len(input logic rs, input logic [7:0] data);
        logic slow;
        slow = !rs && (data >= 8'h01 && data <= 8'h03);
        return 2 * S + 2 * EH + G + (slow ? LD : CD) + 1;
    endfunction

    // Expected pins k cycles after the handshake cycle.
    function automatic logic [7:0] exp_byte(input int k, input logic rs, input logic [7:0] data);
        int   hi_e_end, lo_set_end, lo_e_end, gap_end;
        logic e;
        logic [3:0] nib;
        hi_e_end   = S + EH;
        gap_end    = S + EH + G;
        lo_set_end = 2 * S + EH + G;
        lo_e_end   = 2 * S + 2 * EH + G;
        e   = (k > S && k <= hi_e_end) || (k > lo_set_end && k <= lo_e_end);
        nib = (k <= gap_end) ? data[7:4] : data[3:0];
        return {1'b1, (k >= byte_len(rs, data)), e, rs, nib};
    endfunction

    task automatic check_init_seq();
        int rise;
        logic [7:0] exp;
        rise = -1;
        for (int t = 0; t <= INIT_LEN; t++) begin
            if (t > 0) @(negedge clk);
            exp = exp_init(t);
            total++;
            if (obs1 !== exp) begin
                bad++;
                $display("FAIL init t=%0d got=%b want=%b", t, obs1, exp);
            end
            if (rise < 0 && bus1.in_ready === 1'b1) rise = t;
        end
        total++;
        if (rise !== 122) begin
            bad++;
            $display("FAIL init_ready_cycle got=%0d want=122", rise);
        end
    endtask

    // Caller sits at a negedge where in_ready is expected high; returns at the negedge
    // where in_ready is next expected high. hold keeps in_valid up with junk data while busy.
    task automatic run_byte(input logic rs, input logic [7:0] data, input bit hold, output int rk);
        int len;
        logic [7:0] exp;
        len = byte_len(rs, data);
        bus1.in_valid = 1'b1;
        bus1.in_rs    = rs;
        bus1.in_data  = data;
        total++;
        if (bus1.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready got=%b want=1", bus1.in_ready);
        end
        rk = -1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            exp = exp_byte(k, rs, data);
            total++;
            if (obs1 !== exp) begin
                bad++;
                $display("FAIL byte rs=%b data=%h k=%0d got=%b want=%b", rs, data, k, obs1, exp);
            end
            if (rk < 0 && bus1.in_ready === 1'b1) rk = k;
            if (k < len) begin
                if (hold) begin
                    bus1.in_rs   = 1'($urandom_range(0, 1));
                    bus1.in_data = 8'($urandom);
                end else begin
                    bus1.in_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus1.in_valid = 1'b0; bus1.in_rs = 1'b0; bus1.in_data = 8'h00;
        bus0.in_valid = 1'b0; bus0.in_rs = 1'b0; bus0.in_data = 8'h00;
        rst1 = 1'b1;
        rst0 = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (obs1 !== 8'h00) begin bad++; $display("FAIL reset_init_en1 got=%b want=00000000", obs1); end
        total++;
        if (obs0 !== 8'h00) begin bad++; $display("FAIL reset_init_en0 got=%b want=00000000", obs0); end
    endtask

    task automatic test_no_init();
        rst0 = 1'b0;
        total++;
        if (obs0 !== 8'h00) begin bad++; $display("FAIL noinit_c0 got=%b want=00000000", obs0); end
        @(negedge clk);
        total++;
        if ({done0, bus0.in_ready, e0} !== 3'b110) begin
            bad++; $display("FAIL noinit_c1 got=%b want=110", {done0, bus0.in_ready, e0});
        end
        for (int i = 0; i < 20; i++) begin
            bus0.in_data = 8'($urandom);
            @(negedge clk);
            total++;
            if ({bus0.in_ready, e0} !== 2'b10) begin
                bad++; $display("FAIL noinit_idle i=%0d got=%b want=10", i, {bus0.in_ready, e0});
            end
        end
        bus0.in_valid = 1'b1; bus0.in_rs = 1'b1; bus0.in_data = 8'hA5;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        total++;
        if ({e0, rs0, d0, bus0.in_ready} !== 7'b0_1_1010_0) begin
            bad++; $display("FAIL noinit_first_setup got=%b want=0110100", {e0, rs0, d0, bus0.in_ready});
        end
        @(negedge clk);
        total++;
        if (e0 !== 1'b1) begin bad++; $display("FAIL noinit_first_e got=%b want=1", e0); end
    endtask

    task automatic test_init();
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check_init_seq();
    endtask

    task automatic test_char();
        int rk;
        run_byte(1'b1, 8'h48, 1'b0, rk);
        total++;
        if (rk !== 14) begin bad++; $display("FAIL char_ready_cycle got=%0d want=14", rk); end
    endtask

    task automatic test_clear();
        int rk;
        run_byte(1'b0, 8'h01, 1'b0, rk);
        total++;
        if (rk !== 29) begin bad++; $display("FAIL clear_ready_cycle got=%0d want=29", rk); end
    endtask

    task automatic test_random();
        int rk;
        logic rs;
        logic [7:0] data;
        for (int i = 0; i < 10; i++) begin
            rs   = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs   = 1'b0;
                data = 8'($urandom_range(1, 3));
            end
            run_byte(rs, data, 1'b0, rk);
            repeat ($urandom_range(0, 3)) begin
                bus1.in_data = 8'($urandom);
                @(negedge clk);
                total++;
                if (obs1 !== {1'b1, 1'b1, 1'b0, rs, data[3:0]}) begin
                    bad++;
                    $display("FAIL idle_hold got=%b want=%b", obs1, {1'b1, 1'b1, 1'b0, rs, data[3:0]});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int rk;
        logic rs;
        logic [7:0] data;
        for (int i = 0; i < 5; i++) begin
            rs   = 1'($urandom_range(0, 1));
            data = (i == 2) ? 8'h02 : 8'($urandom);
            run_byte(rs, data, 1'b1, rk);
            total++;
            if (rk !== byte_len(rs, data)) begin
                bad++; $display("FAIL b2b_ready_cycle got=%0d want=%0d", rk, byte_len(rs, data));
            end
        end
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int rk;
        bus1.in_valid = 1'b1;
        bus1.in_rs    = 1'b1;
        bus1.in_data  = 8'h6C;
        total++;
        if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b want=1", bus1.in_ready); end
        for (int k = 1; k <= 2 * S + EH + G + 1; k++) begin
            @(negedge clk);
            bus1.in_valid = 1'b0;
        end
        total++;
        if ({e1, d1} !== 5'b1_1100) begin bad++; $display("FAIL mid_lo_ehi got=%b want=11100", {e1, d1}); end
        rst1 = 1'b1;
        @(negedge clk);
        total++;
        if (obs1 !== 8'h00) begin bad++; $display("FAIL mid_reset got=%b want=00000000", obs1); end
        rst1 = 1'b0;
        check_init_seq();
        run_byte(1'b1, 8'h21, 1'b0, rk);
    endtask

    initial begin
        test_reset();
        test_no_init();
        test_init();
        test_char();
        test_clear();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
